// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types.
// Word/register widths and the EX/MEM access FSM state.
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HALTED = 2'd2
  } memstage_state_t;

endpackage

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with data-memory request FSM.
// Issues each load/store once, stalls until dhit, latches halt.
import cpu_types_pkg::*;

module ex_mem_stage (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        enable_EX_MEM,
  input  logic        flush_EX_MEM,
  input  logic        dREN_ID_EX,
  input  logic        dWEN_ID_EX,
  input  logic        WEN_ID_EX,
  input  logic        halt_ID_EX,
  input  logic [4:0]  wsel_EX,
  input  logic [31:0] alu_out_EX,
  input  logic [31:0] rdat2_EX,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        WEN_EX_MEM,
  output logic [4:0]  wsel_EX_MEM,
  output logic [31:0] alu_out_EX_MEM,
  output logic [31:0] dload_EX_MEM,
  output logic        memtoreg_EX_MEM,
  output logic        halt_EX_MEM,
  output logic        mem_stall
);

  memstage_state_t state, state_n;

  logic     dren_r;
  logic     dwen_r;
  logic     wen_r;
  logic     halt_r;
  regbits_t wsel_r;
  word_t    alu_r;
  word_t    rdat2_r;
  word_t    dload_r;

  logic in_access;
  logic live;
  logic do_flush;
  logic do_load;
  logic done_rd;

  assign in_access = (state == ACCESS);
  assign mem_stall = in_access & ~dhit;
  assign live      = (state != HALTED) & ~mem_stall;
  assign do_flush  = live & flush_EX_MEM;
  assign do_load   = live & ~flush_EX_MEM & enable_EX_MEM;
  assign done_rd   = in_access & dhit & dren_r;

  assign dmemREN         = in_access & dren_r;
  assign dmemWEN         = in_access & dwen_r;
  assign dmemaddr        = alu_r;
  assign dmemstore       = rdat2_r;
  assign WEN_EX_MEM      = wen_r;
  assign wsel_EX_MEM     = wsel_r;
  assign alu_out_EX_MEM  = alu_r;
  assign dload_EX_MEM    = dload_r;
  assign memtoreg_EX_MEM = dren_r;
  assign halt_EX_MEM     = halt_r;

  always_comb begin
    state_n = state;
    priority case (1'b1)
      (state == HALTED): state_n = HALTED;
      mem_stall:         state_n = ACCESS;
      flush_EX_MEM:      state_n = IDLE;
      enable_EX_MEM: begin
        if (halt_ID_EX)
          state_n = HALTED;
        else if (dREN_ID_EX | dWEN_ID_EX)
          state_n = ACCESS;
        else
          state_n = IDLE;
      end
      default: begin
        // a held op that just completed must not be reissued
        if (in_access)
          state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dren_r  <= 1'b0;
      dwen_r  <= 1'b0;
      wen_r   <= 1'b0;
      halt_r  <= 1'b0;
      wsel_r  <= '0;
      alu_r   <= '0;
      rdat2_r <= '0;
      dload_r <= '0;
    end else begin
      if (done_rd)
        dload_r <= dmemload;
      if (do_flush) begin
        dren_r  <= 1'b0;
        dwen_r  <= 1'b0;
        wen_r   <= 1'b0;
        halt_r  <= 1'b0;
        wsel_r  <= '0;
        alu_r   <= '0;
        rdat2_r <= '0;
        dload_r <= '0;
      end else if (do_load) begin
        dren_r  <= dREN_ID_EX;
        // read+write together is illegal; resolve as a load
        dwen_r  <= dWEN_ID_EX & ~dREN_ID_EX;
        wen_r   <= WEN_ID_EX;
        halt_r  <= halt_ID_EX;
        wsel_r  <= wsel_EX;
        alu_r   <= alu_out_EX;
        rdat2_r <= rdat2_EX;
      end
    end
  end

  a_no_rw: assert property (
    @(posedge CLK) disable iff (!nRST)
    do_load |-> !(dREN_ID_EX && dWEN_ID_EX)
  );

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed testbench for ex_mem_stage.
// One task per scenario, hand-computed expectations.
module tb_ex_mem_stage;

  logic        CLK;
  logic        nRST;
  logic        enable_EX_MEM;
  logic        flush_EX_MEM;
  logic        dREN_ID_EX;
  logic        dWEN_ID_EX;
  logic        WEN_ID_EX;
  logic        halt_ID_EX;
  logic [4:0]  wsel_EX;
  logic [31:0] alu_out_EX;
  logic [31:0] rdat2_EX;
  logic        dhit;
  logic [31:0] dmemload;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        WEN_EX_MEM;
  logic [4:0]  wsel_EX_MEM;
  logic [31:0] alu_out_EX_MEM;
  logic [31:0] dload_EX_MEM;
  logic        memtoreg_EX_MEM;
  logic        halt_EX_MEM;
  logic        mem_stall;

  int checks = 0;
  int errors = 0;

  ex_mem_stage dut (
    .CLK(CLK),
    .nRST(nRST),
    .enable_EX_MEM(enable_EX_MEM),
    .flush_EX_MEM(flush_EX_MEM),
    .dREN_ID_EX(dREN_ID_EX),
    .dWEN_ID_EX(dWEN_ID_EX),
    .WEN_ID_EX(WEN_ID_EX),
    .halt_ID_EX(halt_ID_EX),
    .wsel_EX(wsel_EX),
    .alu_out_EX(alu_out_EX),
    .rdat2_EX(rdat2_EX),
    .dhit(dhit),
    .dmemload(dmemload),
    .dmemREN(dmemREN),
    .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr),
    .dmemstore(dmemstore),
    .WEN_EX_MEM(WEN_EX_MEM),
    .wsel_EX_MEM(wsel_EX_MEM),
    .alu_out_EX_MEM(alu_out_EX_MEM),
    .dload_EX_MEM(dload_EX_MEM),
    .memtoreg_EX_MEM(memtoreg_EX_MEM),
    .halt_EX_MEM(halt_EX_MEM),
    .mem_stall(mem_stall)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    enable_EX_MEM = 0;
    flush_EX_MEM  = 0;
    dREN_ID_EX    = 0;
    dWEN_ID_EX    = 0;
    WEN_ID_EX     = 0;
    halt_ID_EX    = 0;
    wsel_EX       = '0;
    alu_out_EX    = '0;
    rdat2_EX      = '0;
    dhit          = 0;
    dmemload      = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    nRST = 0;
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1;
  endtask

  task automatic issue_load(input logic [31:0] a, input logic [4:0] ws);
    enable_EX_MEM = 1;
    dREN_ID_EX    = 1;
    WEN_ID_EX     = 1;
    wsel_EX       = ws;
    alu_out_EX    = a;
    step();
    idle_inputs();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({dmemREN, dmemWEN, WEN_EX_MEM, memtoreg_EX_MEM,
         halt_EX_MEM, mem_stall} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000000",
        {dmemREN, dmemWEN, WEN_EX_MEM, memtoreg_EX_MEM,
         halt_EX_MEM, mem_stall});
    end
    checks++;
    if ({dmemaddr, dmemstore, dload_EX_MEM, wsel_EX_MEM} !== '0) begin
      errors++;
      $display("FAIL reset_data: addr=%h store=%h dload=%h wsel=%0d want 0",
        dmemaddr, dmemstore, dload_EX_MEM, wsel_EX_MEM);
    end
  endtask

  task automatic test_load();
    int ren_n;
    int stall_n;
    ren_n   = 0;
    stall_n = 0;
    issue_load(32'h0000_0040, 5'd5);
    checks++;
    if (dmemaddr !== 32'h40) begin
      errors++;
      $display("FAIL load_addr: got %h want 00000040", dmemaddr);
    end
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        dhit     = 1;
        dmemload = 32'hDEAD_BEEF;
      end
      #1;
      if (dmemREN) ren_n++;
      if (mem_stall) stall_n++;
      step();
      dhit = 0;
    end
    checks++;
    if (ren_n !== 3) begin
      errors++;
      $display("FAIL load_ren_cycles: got %0d want 3", ren_n);
    end
    checks++;
    if (stall_n !== 2) begin
      errors++;
      $display("FAIL load_stall_cycles: got %0d want 2", stall_n);
    end
    checks++;
    if (dload_EX_MEM !== 32'hDEAD_BEEF || dmemREN !== 1'b0) begin
      errors++;
      $display("FAIL load_done: dload=%h ren=%b want deadbeef 0",
        dload_EX_MEM, dmemREN);
    end
    checks++;
    if (memtoreg_EX_MEM !== 1'b1 || wsel_EX_MEM !== 5'd5 ||
        WEN_EX_MEM !== 1'b1) begin
      errors++;
      $display("FAIL load_fields: m2r=%b wsel=%0d wen=%b want 1 5 1",
        memtoreg_EX_MEM, wsel_EX_MEM, WEN_EX_MEM);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (dmemREN !== 1'b0 || mem_stall !== 1'b0 ||
          dload_EX_MEM !== 32'hDEAD_BEEF || dmemaddr !== 32'h40) begin
        errors++;
        $display("FAIL hold_%0d: ren=%b stall=%b dload=%h addr=%h want 0 0 deadbeef 40",
          i, dmemREN, mem_stall, dload_EX_MEM, dmemaddr);
      end
    end
  endtask

  task automatic test_store();
    int wen_n;
    int stall_n;
    wen_n   = 0;
    stall_n = 0;
    enable_EX_MEM = 1;
    dWEN_ID_EX    = 1;
    alu_out_EX    = 32'h80;
    rdat2_EX      = 32'h1234_5678;
    step();
    idle_inputs();
    dhit = 1;
    #1;
    checks++;
    if (dmemstore !== 32'h1234_5678 || dmemaddr !== 32'h80) begin
      errors++;
      $display("FAIL store_bus: store=%h addr=%h want 12345678 80",
        dmemstore, dmemaddr);
    end
    for (int i = 0; i < 4; i++) begin
      if (dmemWEN) wen_n++;
      if (mem_stall) stall_n++;
      step();
      dhit = 0;
      #1;
    end
    checks++;
    if (wen_n !== 1) begin
      errors++;
      $display("FAIL store_wen_cycles: got %0d want 1", wen_n);
    end
    checks++;
    if (stall_n !== 0) begin
      errors++;
      $display("FAIL store_stall_cycles: got %0d want 0", stall_n);
    end
  endtask

  task automatic test_back_to_back();
    issue_load(32'h40, 5'd3);
    checks++;
    if (dmemREN !== 1'b1 || mem_stall !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: ren=%b stall=%b want 1 1", dmemREN, mem_stall);
    end
    dhit          = 1;
    dmemload      = 32'h1111_1111;
    enable_EX_MEM = 1;
    dREN_ID_EX    = 1;
    WEN_ID_EX     = 1;
    wsel_EX       = 5'd4;
    alu_out_EX    = 32'h44;
    #1;
    checks++;
    if (dmemREN !== 1'b1 || dmemaddr !== 32'h40 || mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL b2b_hit1: ren=%b addr=%h stall=%b want 1 40 0",
        dmemREN, dmemaddr, mem_stall);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (dmemREN !== 1'b1 || dmemaddr !== 32'h44 ||
        dload_EX_MEM !== 32'h1111_1111) begin
      errors++;
      $display("FAIL b2b_second: ren=%b addr=%h dload=%h want 1 44 11111111",
        dmemREN, dmemaddr, dload_EX_MEM);
    end
    dhit     = 1;
    dmemload = 32'h2222_2222;
    step();
    idle_inputs();
    checks++;
    if (dload_EX_MEM !== 32'h2222_2222 || dmemREN !== 1'b0 ||
        wsel_EX_MEM !== 5'd4) begin
      errors++;
      $display("FAIL b2b_done: dload=%h ren=%b wsel=%0d want 22222222 0 4",
        dload_EX_MEM, dmemREN, wsel_EX_MEM);
    end
  endtask

  task automatic test_flush();
    issue_load(32'h100, 5'd7);
    flush_EX_MEM = 1;
    step();
    checks++;
    if (WEN_EX_MEM !== 1'b1 || wsel_EX_MEM !== 5'd7 ||
        dmemREN !== 1'b1 || mem_stall !== 1'b1) begin
      errors++;
      $display("FAIL flush_ignored: wen=%b wsel=%0d ren=%b stall=%b want 1 7 1 1",
        WEN_EX_MEM, wsel_EX_MEM, dmemREN, mem_stall);
    end
    dhit = 1;
    step();
    dhit = 0;
    #1;
    checks++;
    if (WEN_EX_MEM !== 1'b0 || wsel_EX_MEM !== 5'd0 ||
        dmemREN !== 1'b0 || mem_stall !== 1'b0 || dmemaddr !== 32'h0) begin
      errors++;
      $display("FAIL flush_bubble: wen=%b wsel=%0d ren=%b stall=%b addr=%h want 0 0 0 0 0",
        WEN_EX_MEM, wsel_EX_MEM, dmemREN, mem_stall, dmemaddr);
    end
    flush_EX_MEM = 0;
  endtask

  task automatic test_ignore_dhit_idle();
    dhit     = 1;
    dmemload = 32'hCAFE_F00D;
    step();
    idle_inputs();
    checks++;
    if (dload_EX_MEM !== 32'h0 || dmemREN !== 1'b0) begin
      errors++;
      $display("FAIL dhit_idle: dload=%h ren=%b want 0 0", dload_EX_MEM, dmemREN);
    end
  endtask

  task automatic test_halt();
    enable_EX_MEM = 1;
    halt_ID_EX    = 1;
    step();
    halt_ID_EX = 0;
    dREN_ID_EX = 1;
    dWEN_ID_EX = 0;
    alu_out_EX = 32'h40;
    checks++;
    if (halt_EX_MEM !== 1'b1) begin
      errors++;
      $display("FAIL halt_set: got %b want 1", halt_EX_MEM);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (halt_EX_MEM !== 1'b1 || dmemREN !== 1'b0 || dmemWEN !== 1'b0 ||
          dmemaddr !== 32'h0) begin
        errors++;
        $display("FAIL halt_hold_%0d: halt=%b ren=%b wen=%b addr=%h want 1 0 0 0",
          i, halt_EX_MEM, dmemREN, dmemWEN, dmemaddr);
      end
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    issue_load(32'h200, 5'd9);
    #2;
    nRST = 0;
    #1;
    checks++;
    if ({dmemREN, mem_stall, WEN_EX_MEM, memtoreg_EX_MEM} !== 4'b0 ||
        dmemaddr !== 32'h0 || wsel_EX_MEM !== 5'd0) begin
      errors++;
      $display("FAIL async_reset: ren=%b stall=%b wen=%b m2r=%b addr=%h wsel=%0d want all 0",
        dmemREN, mem_stall, WEN_EX_MEM, memtoreg_EX_MEM, dmemaddr, wsel_EX_MEM);
    end
    step();
    nRST = 1;
    step();
    checks++;
    if (dmemREN !== 1'b0 || mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: ren=%b stall=%b want 0 0",
        dmemREN, mem_stall);
    end
  endtask

  initial begin
    nRST = 1;
    idle_inputs();
    test_reset();
    test_load();
    test_hold();
    test_store();
    test_back_to_back();
    test_flush();
    test_ignore_dhit_idle();
    test_halt();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
